// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared types and constants for the result collector
package collector_pkg;

  // Data width of the upstream engine's data_out word
  localparam int ENGINE_WIDTH = 8;

  // Collector FSM states
  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word fall-through FIFO with separate occupancy count
module result_fifo
  import collector_pkg::*;
#(
  parameter int WIDTH = ENGINE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and count; push/pop arrive already
  // qualified by the owner, so no full/empty guarding is repeated here
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // State registers; reset also clears storage so the head reads as zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Status and fall-through head, all derived from registers
  always_comb begin
    count = count_q;
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    rdata = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - batches engine results and releases them over a valid/ready stream
module result_collector
  import collector_pkg::*;
#(
  parameter int WIDTH = ENGINE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_done,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty,
  output logic                          draining,
  output logic                          overflow,
  output logic [WIDTH-1:0]              checksum
);

  localparam int CNT_W = count_width(DEPTH);

  state_e           state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] checksum_q, checksum_d;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] post_count;

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake qualification; a write while full is dropped even if a pop
  // frees a slot on the same edge
  always_comb begin
    out_valid = (state_q == DRAIN) && !fifo_empty;
    push      = in_done && !fifo_full;
    pop       = out_valid && out_ready;
  end

  // FSM next state, decided on the occupancy after this edge's push/pop
  always_comb begin
    state_d    = state_q;
    post_count = fifo_count + CNT_W'(push) - CNT_W'(pop);
    case (state_q)
      COLLECT: begin
        if (post_count == CNT_W'(DEPTH)) begin
          state_d = DRAIN;
        end else if (flush && (post_count != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (post_count == '0) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Sticky overflow and running checksum of accepted words only
  always_comb begin
    overflow_d = overflow_q | (in_done & fifo_full);
    checksum_d = push ? (checksum_q + in_data) : checksum_q;
  end

  // Registers for FSM state, overflow and checksum
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= COLLECT;
      overflow_q <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      checksum_q <= checksum_d;
    end
  end

  // Status outputs straight from registers
  always_comb begin
    count    = fifo_count;
    full     = fifo_full;
    empty    = fifo_empty;
    draining = (state_q == DRAIN);
    overflow = overflow_q;
    checksum = checksum_q;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the `medium_fsm` processing engine. It captures each `data_out` word that engine presents with its `done` pulse, buffers words in a small FIFO, and releases them in batches over a valid/ready stream. It keeps a running modulo checksum and a sticky overflow flag for the bench and for system status. Batch release is triggered by a full buffer or an explicit flush.

## Interface
Parameters:
- `WIDTH`, 8: data word width; matches the engine's `data_out`.
- `DEPTH`, 4: FIFO depth; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk`).
- `in_done`  in  1  one-cycle pulse from the engine's `done`; write strobe.
- `in_data`  in  WIDTH  engine `data_out`; sampled when `in_done`=1.
- `flush`  in  1  pulse; requests release of a partial batch.
- `out_valid`  out  1  head word available on `out_data`.
- `out_ready`  in  1  consumer accepts the head word.
- `out_data`  out  WIDTH  FIFO head word; valid only while `out_valid`=1.
- `count`  out  clog2(DEPTH)+1  number of stored words.
- `full`  out  1  `count`==DEPTH.
- `empty`  out  1  `count`==0.
- `draining`  out  1  FSM is in DRAIN.
- `overflow`  out  1  sticky; set when a write is dropped.
- `checksum`  out  WIDTH  sum of all accepted words since reset, mod 2^WIDTH.

## Operation
- FSM states: COLLECT and DRAIN.
- **COLLECT:** `out_valid`=0. Writes are accepted while not full.
  - Go to DRAIN when a write makes `count`==DEPTH.
  - Go to DRAIN when `flush`=1 and `count`>0 (post-write count).
  - `flush` with an empty FIFO is ignored.
- **DRAIN:** `out_valid`=!`empty`.
  - A pop occurs when `out_valid`&&`out_ready`.
  - Writes are still accepted while not full.
  - Go to COLLECT on the edge where `count` becomes 0.
  - `flush` in DRAIN has no effect.
- **Write acceptance:** `in_done`=1 and `count`<DEPTH. A write while full is dropped, even if a pop happens the same cycle, and sets `overflow`.
- **Simultaneous write and pop:** both occur and `count` is unchanged. A last pop with a simultaneous write leaves `count`=1, so the FSM stays in DRAIN.
- **Pointers:** `rd_ptr` and `wr_ptr` are clog2(DEPTH) bits and wrap naturally. `count` is tracked separately.
- **Checksum:** `checksum` <= `checksum`+`in_data` on each accepted write. It wraps mod 2^WIDTH. Dropped words are not added.
- `out_data` = mem[`rd_ptr`] (first-word fall-through).
- **Reset:** `reset`=0 at a rising edge gives the following, with no partial drain completion:
  - state COLLECT; pointers and `count` 0;
  - `empty`=1; `full`=0, `out_valid`=0, `draining`=0, `overflow`=0, `checksum`=0;
  - `out_data`=0. Memory is cleared, or `out_data` is masked to 0 while empty.

## Timing
- **Write latency:** `in_done` sampled at edge N. `count`, `empty` and `checksum` update after N.
- **Full release:** if the write at edge N fills the FIFO, `draining`=1 and `out_valid`=1 in the cycle after N.
- **Flush release:** `flush` at edge N with non-empty content gives `out_valid`=1 in the cycle after N.
- **Pop:** at edge M, `rd_ptr` advances and the next head appears on `out_data` in the cycle after M.
- **Throughput:** one pop per cycle while `out_ready`=1.
- **Holding:** `out_valid` and `out_data` stay stable while `out_ready`=0.
- **Return to COLLECT:** after the final pop at edge M, `out_valid`=0 and `draining`=0 in the cycle after M.
- All outputs are registered or derived from registers only. No combinational path from `out_ready` or `in_done` to any output.

## Structure
- Shared package `collector_pkg`:
  - state enum (`COLLECT`, `DRAIN`);
  - function for the `count` width;
  - `WIDTH` default constant shared with the engine's data width.
- One sub-module: `result_fifo`.
  - Holds storage, pointers, count, full/empty and first-word fall-through read.
  - Ports: push, pop, wdata, rdata.
- The top level holds the FSM, push/pop qualification, overflow and checksum.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release. Check all outputs at reset values: `empty`=1, `checksum`=0.
- **Full release:** with `out_ready`=0, write 0x11,0x22,0x33,0x44. `full`=1 and `out_valid`=1 one cycle later. Raise `out_ready`; 0x11..0x44 drain on 4 consecutive cycles, `empty`=1, back to COLLECT. `checksum`=0xAA.
- **Overflow:** keep the FIFO full with `out_ready`=0 and pulse `in_done` with 0x55. `overflow`=1 and stays 1. `count` stays 4; `checksum` unchanged; 0x55 never output.
- **Flush partial:** write 0x0A,0x0B, then pulse `flush`. `out_valid`=1 next cycle and 2 words drain. Flush on an empty FIFO: `out_valid` stays 0.
- **Simultaneous write and last pop:** one word in DRAIN; pop and write 0x77 in the same cycle. `count` stays 1, `draining` stays 1, 0x77 is output next.
- **Reset mid-drain and checksum wrap:** assert reset mid-drain; FIFO empties and the FSM returns to COLLECT next cycle. Then write 0xF0,0x20: `checksum`=0x10.
